// File: rtl/nanov_spi_arbiter_if.sv
// Requester and SPI pin bundle for nanov_spi_arbiter.
// The slave side is the arbiter; the master side is the core plus the RAM pins.
interface nanov_spi_arbiter_if;
    logic        fetch_req;
    logic [23:0] fetch_addr;
    logic        fetch_done;
    logic        data_req;
    logic        data_we;
    logic [23:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_done;
    logic [31:0] rdata;
    logic        busy;
    logic        spi_select;
    logic        spi_out;
    logic        spi_data_in;
    logic        spi_clk_enable;

    modport slave (
        input  fetch_req, fetch_addr, data_req, data_we, data_addr, data_wdata, spi_data_in,
        output fetch_done, data_done, rdata, busy, spi_select, spi_out, spi_clk_enable
    );

    modport master (
        output fetch_req, fetch_addr, data_req, data_we, data_addr, data_wdata, spi_data_in,
        input  fetch_done, data_done, rdata, busy, spi_select, spi_out, spi_clk_enable
    );
endinterface

// File: rtl/nanov_spi_arbiter.sv
// Round-robin arbiter and SPI RAM sequencer for nanoV fetch and load/store word accesses.
// Command, address and write data go out through one shift register; all outputs are registered.
module nanov_spi_arbiter #(
    parameter int unsigned ADDR_BITS = 24,
    parameter logic [7:0]  READ_CMD  = 8'h03,
    parameter logic [7:0]  WRITE_CMD = 8'h02
) (
    input  logic                clk,
    input  logic                rst,
    nanov_spi_arbiter_if.slave  bus
);
    localparam int unsigned SHIFT_BITS = 8 + ADDR_BITS + 32;
    localparam logic [4:0]  ADDR_LAST  = 5'(ADDR_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_END} state_t;

    state_t                state_q, state_d;
    logic [4:0]            cnt_q, cnt_d;
    logic [SHIFT_BITS-1:0] shift_q, shift_d;
    logic [31:0]           rx_q, rx_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  we_q, we_d;
    logic                  grant_fetch_q, grant_fetch_d;
    logic                  last_fetch_q, last_fetch_d;
    logic                  select_q, select_d;
    logic                  out_q, out_d;
    logic                  clk_en_q, clk_en_d;
    logic                  fetch_done_q, fetch_done_d;
    logic                  data_done_q, data_done_d;
    logic                  busy_q, busy_d;

    logic                  arb_valid_s;
    logic                  arb_fetch_s;
    logic                  arb_we_s;
    logic [23:0]           arb_addr_s;
    logic [SHIFT_BITS-1:0] load_s;

    // Wire order is byte0 first, so the word is byte-reversed on the way in and out.
    function automatic logic [31:0] swap_bytes(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Pick the next requester and build the full outgoing bit stream for it.
    always_comb begin
        arb_valid_s = bus.fetch_req | bus.data_req;
        if (bus.fetch_req && bus.data_req) begin
            arb_fetch_s = ~last_fetch_q;
        end else begin
            arb_fetch_s = bus.fetch_req;
        end
        arb_we_s   = ~arb_fetch_s & bus.data_we;
        arb_addr_s = arb_fetch_s ? bus.fetch_addr : bus.data_addr;
        load_s     = {(arb_we_s ? WRITE_CMD : READ_CMD),
                      arb_addr_s[ADDR_BITS-1:2], 2'b00,
                      (arb_we_s ? swap_bytes(bus.data_wdata) : 32'h0000_0000)};
    end

    // Sequencer next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shift_d       = shift_q;
        rx_d          = rx_q;
        rdata_d       = rdata_q;
        we_d          = we_q;
        grant_fetch_d = grant_fetch_q;
        last_fetch_d  = last_fetch_q;
        select_d      = 1'b1;
        out_d         = 1'b0;
        clk_en_d      = 1'b0;
        fetch_done_d  = 1'b0;
        data_done_d   = 1'b0;
        case (state_q)
            S_IDLE, S_END: begin
                if (arb_valid_s) begin
                    state_d       = S_CMD;
                    cnt_d         = 5'd0;
                    out_d         = load_s[SHIFT_BITS-1];
                    shift_d       = {load_s[SHIFT_BITS-2:0], 1'b0};
                    we_d          = arb_we_s;
                    grant_fetch_d = arb_fetch_s;
                    last_fetch_d  = arb_fetch_s;
                    select_d      = 1'b0;
                    clk_en_d      = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CMD, S_ADDR: begin
                select_d = 1'b0;
                clk_en_d = 1'b1;
                out_d    = shift_q[SHIFT_BITS-1];
                shift_d  = {shift_q[SHIFT_BITS-2:0], 1'b0};
                cnt_d    = cnt_q + 5'd1;
                if (state_q == S_CMD && cnt_q == 5'd7) begin
                    state_d = S_ADDR;
                    cnt_d   = 5'd0;
                end else if (state_q == S_ADDR && cnt_q == ADDR_LAST) begin
                    state_d = S_DATA;
                    cnt_d   = 5'd0;
                end else begin
                    state_d = state_q;
                end
            end
            S_DATA: begin
                rx_d  = {rx_q[30:0], bus.spi_data_in};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d      = S_END;
                    fetch_done_d = grant_fetch_q;
                    data_done_d  = ~grant_fetch_q;
                    if (!we_q) begin
                        rdata_d = swap_bytes(rx_d);
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    select_d = 1'b0;
                    clk_en_d = 1'b1;
                    out_d    = shift_q[SHIFT_BITS-1];
                    shift_d  = {shift_q[SHIFT_BITS-2:0], 1'b0};
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs; reset drops select and abandons any transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= 5'd0;
            shift_q       <= '0;
            rx_q          <= 32'h0000_0000;
            rdata_q       <= 32'h0000_0000;
            we_q          <= 1'b0;
            grant_fetch_q <= 1'b0;
            last_fetch_q  <= 1'b1;
            select_q      <= 1'b1;
            out_q         <= 1'b0;
            clk_en_q      <= 1'b0;
            fetch_done_q  <= 1'b0;
            data_done_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shift_q       <= shift_d;
            rx_q          <= rx_d;
            rdata_q       <= rdata_d;
            we_q          <= we_d;
            grant_fetch_q <= grant_fetch_d;
            last_fetch_q  <= last_fetch_d;
            select_q      <= select_d;
            out_q         <= out_d;
            clk_en_q      <= clk_en_d;
            fetch_done_q  <= fetch_done_d;
            data_done_q   <= data_done_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.spi_select     = select_q;
    assign bus.spi_out        = out_q;
    assign bus.spi_clk_enable = clk_en_q;
    assign bus.fetch_done     = fetch_done_q;
    assign bus.data_done      = data_done_q;
    assign bus.rdata          = rdata_q;
    assign bus.busy           = busy_q;
endmodule

// File: tb/tb_nanov_spi_arbiter.sv
// Directed bench for nanov_spi_arbiter: a 24-bit and a 16-bit address instance
// with a small SPI RAM model that returns ram_word during the data phase.
module tb_nanov_spi_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nanov_spi_arbiter_if bus_a ();
    nanov_spi_arbiter_if bus_b ();

    nanov_spi_arbiter #(.ADDR_BITS(24), .READ_CMD(8'h03), .WRITE_CMD(8'h02)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave));
    nanov_spi_arbiter #(.ADDR_BITS(16), .READ_CMD(8'h03), .WRITE_CMD(8'h02)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave));

    int          checks = 0;
    int          errors = 0;
    logic [31:0] ram_word;
    logic [1:0]  sel_w, mosi_w, en_w, fd_w, dd_w;
    int          low_cnt [2]   = '{0, 0};
    int          high_cnt [2]  = '{0, 0};
    int          last_low [2]  = '{0, 0};
    int          last_high [2] = '{0, 0};
    int          fdone_cnt [2] = '{0, 0};
    int          en_bad = 0;
    int          both_bad = 0;
    logic [63:0] mosi_cap [2];

    assign sel_w  = {bus_b.spi_select, bus_a.spi_select};
    assign mosi_w = {bus_b.spi_out, bus_a.spi_out};
    assign en_w   = {bus_b.spi_clk_enable, bus_a.spi_clk_enable};
    assign fd_w   = {bus_b.fetch_done, bus_a.fetch_done};
    assign dd_w   = {bus_b.data_done, bus_a.data_done};

    function automatic logic miso_bit(input int cnt, input int start, input logic [31:0] word);
        if (cnt >= start && cnt < start + 32) begin
            return word[31 - (cnt - start)];
        end else begin
            return 1'b0;
        end
    endfunction

    // low_cnt is the index of the current select-low cycle, so MISO follows it directly.
    assign bus_a.spi_data_in = bus_a.spi_select ? 1'b0 : miso_bit(low_cnt[0], 32, ram_word);
    assign bus_b.spi_data_in = bus_b.spi_select ? 1'b0 : miso_bit(low_cnt[1], 24, ram_word);

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (en_w[i] == sel_w[i]) en_bad <= en_bad + 1;
            if (fd_w[i] && dd_w[i]) both_bad <= both_bad + 1;
            if (fd_w[i]) fdone_cnt[i] <= fdone_cnt[i] + 1;
            if (!sel_w[i]) begin
                if (high_cnt[i] != 0) last_high[i] <= high_cnt[i];
                high_cnt[i] <= 0;
                low_cnt[i]  <= low_cnt[i] + 1;
                mosi_cap[i] <= {mosi_cap[i][62:0], mosi_w[i]};
            end else begin
                if (low_cnt[i] != 0) last_low[i] <= low_cnt[i];
                low_cnt[i]  <= 0;
                high_cnt[i] <= high_cnt[i] + 1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic done_of(input int inst, input bit is_data);
        if (inst == 0) begin
            return is_data ? bus_a.data_done : bus_a.fetch_done;
        end else begin
            return bus_b.fetch_done;
        end
    endfunction

    task automatic drop_req(input int inst, input bit is_data);
        if (inst == 1) bus_b.fetch_req = 1'b0;
        else if (is_data) bus_a.data_req = 1'b0;
        else bus_a.fetch_req = 1'b0;
    endtask

    // lat counts the request cycle as cycle 1; -1 means the budget ran out.
    task automatic wait_done(input int inst, input bit is_data, input int drop_n, output int lat);
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (n == drop_n) drop_req(inst, is_data);
            if (done_of(inst, is_data)) begin
                lat = n + 1;
                break;
            end
        end
    endtask

    int lat;
    int k;
    int order [4];
    int low_len [4];
    int high_len [4];
    int fcnt_before;
    bit drop_pending;
    bit len_pending;

    initial begin
        rst = 1'b1;
        ram_word = 32'h7856_3412;
        bus_a.fetch_req = 1'b0; bus_a.fetch_addr = 24'h0; bus_a.data_req = 1'b0;
        bus_a.data_we = 1'b0;   bus_a.data_addr = 24'h0;  bus_a.data_wdata = 32'h0;
        bus_b.fetch_req = 1'b0; bus_b.fetch_addr = 24'h0; bus_b.data_req = 1'b0;
        bus_b.data_we = 1'b0;   bus_b.data_addr = 24'h0;  bus_b.data_wdata = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_select", 64'(bus_a.spi_select), 64'd1);
        check_eq("rst_mosi", 64'(bus_a.spi_out), 64'd0);
        check_eq("rst_clk_en", 64'(bus_a.spi_clk_enable), 64'd0);
        check_eq("rst_dones", 64'({bus_a.fetch_done, bus_a.data_done}), 64'd0);
        check_eq("rst_busy", 64'(bus_a.busy), 64'd0);
        check_eq("rst_rdata", 64'(bus_a.rdata), 64'd0);
        check_eq("rst_select_b", 64'(bus_b.spi_select), 64'd1);

        // Both requesters held: expect data, fetch, data, fetch back to back.
        bus_a.fetch_addr = 24'h000200;
        bus_a.data_addr  = 24'h000300;
        bus_a.fetch_req  = 1'b1;
        bus_a.data_req   = 1'b1;
        k = 0; drop_pending = 1'b0; len_pending = 1'b0;
        for (int n = 0; n < 400 && (k < 4 || len_pending); n++) begin
            @(negedge clk);
            if (drop_pending) begin
                bus_a.fetch_req = 1'b0;
                bus_a.data_req  = 1'b0;
                drop_pending = 1'b0;
            end
            if (len_pending) begin
                low_len[k-1] = last_low[0];
                len_pending = 1'b0;
            end
            if (bus_a.data_done || bus_a.fetch_done) begin
                order[k]    = int'(bus_a.data_done);
                high_len[k] = last_high[0];
                k++;
                len_pending = 1'b1;
                if (k == 3) drop_pending = 1'b1;
            end
        end
        check_eq("rr_count", 64'(k), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("rr_grant%0d", i), 64'(order[i]), (i % 2 == 0) ? 64'd1 : 64'd0);
            check_eq($sformatf("rr_low%0d", i), 64'(low_len[i]), 64'd64);
            if (i > 0) check_eq($sformatf("rr_gap%0d", i), 64'(high_len[i]), 64'd1);
        end
        repeat (2) @(negedge clk);
        check_eq("rr_idle_busy", 64'(bus_a.busy), 64'd0);

        // Fetch read, request dropped in the third CMD cycle.
        ram_word = 32'h7856_3412;
        bus_a.fetch_addr = 24'h000104;
        bus_a.fetch_req  = 1'b1;
        wait_done(0, 1'b0, 3, lat);
        check_eq("fetch_latency", 64'(lat), 64'd66);
        check_eq("fetch_rdata", 64'(bus_a.rdata), 64'h1234_5678);
        check_eq("fetch_no_data_done", 64'(bus_a.data_done), 64'd0);
        @(negedge clk);
        check_eq("fetch_mosi", mosi_cap[0], {8'h03, 24'h000104, 32'h0});
        check_eq("fetch_low_len", 64'(last_low[0]), 64'd64);
        check_eq("fetch_rdata_held", 64'(bus_a.rdata), 64'h1234_5678);

        // Data write: address low bits masked, bytes little-endian on the wire.
        ram_word = 32'hA5C3_3C5A;
        bus_a.data_we    = 1'b1;
        bus_a.data_addr  = 24'h0000FF;
        bus_a.data_wdata = 32'hDEAD_BEEF;
        bus_a.data_req   = 1'b1;
        wait_done(0, 1'b1, 3, lat);
        check_eq("write_latency", 64'(lat), 64'd66);
        check_eq("write_rdata_kept", 64'(bus_a.rdata), 64'h1234_5678);
        check_eq("write_no_fetch_done", 64'(bus_a.fetch_done), 64'd0);
        @(negedge clk);
        check_eq("write_mosi", mosi_cap[0], {8'h02, 24'h0000FC, 32'hEFBE_ADDE});
        bus_a.data_we = 1'b0;

        // Reset in the 20th ADDR cycle abandons the transfer.
        ram_word = 32'h7856_3412;
        bus_a.fetch_addr = 24'h000400;
        bus_a.fetch_req  = 1'b1;
        fcnt_before = fdone_cnt[0];
        for (int n = 1; n <= 28; n++) begin
            @(negedge clk);
            if (n == 3) bus_a.fetch_req = 1'b0;
        end
        rst = 1'b1;
        #1;
        check_eq("rst_mid_select", 64'(bus_a.spi_select), 64'd1);
        check_eq("rst_mid_clk_en", 64'(bus_a.spi_clk_enable), 64'd0);
        check_eq("rst_mid_busy", 64'(bus_a.busy), 64'd0);
        check_eq("rst_mid_rdata", 64'(bus_a.rdata), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (70) @(negedge clk);
        check_eq("rst_mid_no_done", 64'(fdone_cnt[0]), 64'(fcnt_before));
        bus_a.fetch_addr = 24'h000104;
        bus_a.fetch_req  = 1'b1;
        wait_done(0, 1'b0, 3, lat);
        check_eq("post_rst_latency", 64'(lat), 64'd66);
        check_eq("post_rst_rdata", 64'(bus_a.rdata), 64'h1234_5678);

        // 16-bit address instance.
        @(negedge clk);
        bus_b.fetch_addr = 24'h001234;
        bus_b.fetch_req  = 1'b1;
        wait_done(1, 1'b0, 3, lat);
        check_eq("a16_latency", 64'(lat), 64'd58);
        check_eq("a16_rdata", 64'(bus_b.rdata), 64'h1234_5678);
        @(negedge clk);
        check_eq("a16_mosi", {8'h00, mosi_cap[1][55:0]}, {8'h00, 8'h03, 16'h1234, 32'h0});
        check_eq("a16_low_len", 64'(last_low[1]), 64'd56);

        check_eq("clk_en_vs_select", 64'(en_bad), 64'd0);
        check_eq("done_exclusive", 64'(both_bad), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
